// File: rtl/alu_pkg.sv
// Shared ALU operation codes, main-decoder op classes and sequencer state encoding.
package alu_pkg;

  localparam int unsigned AluAdd = 0;
  localparam int unsigned AluSub = 1;
  localparam int unsigned AluAnd = 2;
  localparam int unsigned AluOr  = 3;
  localparam int unsigned AluSlt = 4;
  localparam int unsigned AluMul = 5;
  localparam int unsigned AluDiv = 6;

  localparam logic [1:0] AluOpRtype = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpSlt   = 2'b10;
  localparam logic [1:0] AluOpAdd   = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMulti = 2'd1,
    StOut   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decode: op class plus funct field to operation code.
module alu_decode
  import alu_pkg::*;
#(
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned CTRL_W  = 3
) (
  input  logic [1:0]         i_alu_op,
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [CTRL_W-1:0]  o_code,
  output logic               o_illegal,
  output logic               o_multi_cycle
);

  always_comb begin
    o_code        = '0;
    o_illegal     = 1'b0;
    o_multi_cycle = 1'b0;
    unique case (i_alu_op)
      AluOpAdd: o_code = CTRL_W'(AluAdd);
      AluOpSub: o_code = CTRL_W'(AluSub);
      AluOpSlt: o_code = CTRL_W'(AluSlt);
      AluOpRtype: begin
        // Defined R-type funct values map directly onto the operation code.
        if (i_funct <= FUNCT_W'(AluDiv)) begin
          o_code        = CTRL_W'(i_funct);
          o_multi_cycle = (i_funct == FUNCT_W'(AluMul)) || (i_funct == FUNCT_W'(AluDiv));
        end else begin
          o_illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: valid/ready handshake around the decoder, with a
// countdown stall for multi-cycle mul/div operations.
module alu_control_seq
  import alu_pkg::*;
#(
  parameter int unsigned FUNCT_W    = 4,
  parameter int unsigned CTRL_W     = 3,
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_control,
  output logic               out_illegal,
  output logic               md_start,
  output logic               busy
);

  localparam int unsigned CntW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MD_LATENCY - 1);

  state_e            r_state, w_state_next;
  logic [CntW-1:0]   r_cnt, w_cnt_next;
  logic [CTRL_W-1:0] r_code;
  logic              r_illegal;

  logic [CTRL_W-1:0] w_code;
  logic              w_illegal;
  logic              w_multi;
  logic              w_accept;

  alu_decode #(
    .FUNCT_W (FUNCT_W),
    .CTRL_W  (CTRL_W)
  ) u_decode (
    .i_alu_op      (alu_op),
    .i_funct       (funct),
    .o_code        (w_code),
    .o_illegal     (w_illegal),
    .o_multi_cycle (w_multi)
  );

  assign in_ready    = (r_state == StIdle) || ((r_state == StOut) && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = (r_state == StOut);
  assign busy        = (r_state == StMulti);
  // The load value is only present on the first MULTI cycle since it is never reloaded there.
  assign md_start    = (r_state == StMulti) && (r_cnt == CntLoad);
  assign alu_control = r_code;
  assign out_illegal = r_illegal;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: ;
      StMulti: begin
        if (r_cnt == '0) begin
          w_state_next = StOut;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StOut: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
    // A new op may arrive from IDLE or overlap the draining OUT cycle.
    if (w_accept) begin
      if (w_multi) begin
        w_state_next = StMulti;
        w_cnt_next   = CntLoad;
      end else begin
        w_state_next = StOut;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_code    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_code    <= w_code;
        r_illegal <= w_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: directed table, handshake corner cases and a
// randomized run against a transaction-level reference model.
module tb_alu_control_seq;

  localparam int unsigned FW  = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned MDL = 4;
  // Multi-cycle ops spend MDL cycles busy, then present their result.
  localparam int MultiLat = MDL + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    alu_op;
  logic [FW-1:0] funct;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] alu_control;
  logic          out_illegal;
  logic          md_start;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rnd_on = 1'b0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] fn;
    int         code;
    bit         ill;
    int         lat;
  } vec_t;

  typedef struct {
    int code;
    bit ill;
    int acc;
    int lat;
  } pend_t;

  vec_t  vt[$];
  pend_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_control_seq #(
    .FUNCT_W    (FW),
    .CTRL_W     (CW),
    .MD_LATENCY (MDL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_control (alu_control),
    .out_illegal (out_illegal),
    .md_start    (md_start),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(logic [1:0] op, logic [3:0] fn, int code, bit ill, int lat);
    vec_t v;
    v.op = op; v.fn = fn; v.code = code; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Reference rules: fixed codes for non-R-type, funct 0..6 passes through, rest illegal.
  function automatic int ref_code(input logic [1:0] op, input logic [3:0] fn);
    case (op)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b10:   return 4;
      default: return (fn <= 4'd6) ? int'(fn) : 0;
    endcase
  endfunction

  function automatic bit ref_ill(input logic [1:0] op, input logic [3:0] fn);
    return (op == 2'b00) && (fn > 4'd6);
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [3:0] fn);
    return ((op == 2'b00) && (fn == 4'd5 || fn == 4'd6)) ? MultiLat : 1;
  endfunction

  // Transaction-level model: at most one op in flight, result due at acc + lat.
  always @(negedge clk) begin
    if (rnd_on) begin
      bit e_ov, e_bz, e_ms, e_ir;
      pend_t p;
      e_ov = 1'b0; e_bz = 1'b0; e_ms = 1'b0;
      if (q.size() > 0) begin
        e_ov = cyc >= q[0].acc + q[0].lat;
        e_bz = cyc <  q[0].acc + q[0].lat;
        e_ms = (q[0].lat > 1) && (cyc == q[0].acc + 1);
      end
      e_ir = (q.size() == 0) || (e_ov && out_ready);
      chk("rnd out_valid", 32'(out_valid), 32'(e_ov));
      chk("rnd in_ready",  32'(in_ready),  32'(e_ir));
      chk("rnd busy",      32'(busy),      32'(e_bz));
      chk("rnd md_start",  32'(md_start),  32'(e_ms));
      if (e_ov) begin
        chk("rnd alu_control", 32'(alu_control), 32'(q[0].code));
        chk("rnd out_illegal", 32'(out_illegal), 32'(q[0].ill));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && e_ir) begin
        p.code = ref_code(alu_op, funct);
        p.ill  = ref_ill(alu_op, funct);
        p.acc  = cyc;
        p.lat  = ref_lat(alu_op, funct);
        q.push_back(p);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish by 200000");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = '0; out_ready = 1'b0;

    vt.push_back(mkv(2'b11, 4'hF, 0, 1'b0, 1));
    vt.push_back(mkv(2'b01, 4'h5, 1, 1'b0, 1));
    vt.push_back(mkv(2'b10, 4'h6, 4, 1'b0, 1));
    vt.push_back(mkv(2'b10, 4'h9, 4, 1'b0, 1));
    vt.push_back(mkv(2'b00, 4'h0, 0, 1'b0, 1));
    vt.push_back(mkv(2'b00, 4'h1, 1, 1'b0, 1));
    vt.push_back(mkv(2'b00, 4'h2, 2, 1'b0, 1));
    vt.push_back(mkv(2'b00, 4'h3, 3, 1'b0, 1));
    vt.push_back(mkv(2'b00, 4'h4, 4, 1'b0, 1));
    vt.push_back(mkv(2'b00, 4'h5, 5, 1'b0, MultiLat));
    vt.push_back(mkv(2'b00, 4'h6, 6, 1'b0, MultiLat));
    vt.push_back(mkv(2'b00, 4'h7, 0, 1'b1, 1));
    vt.push_back(mkv(2'b00, 4'hC, 0, 1'b1, 1));
    vt.push_back(mkv(2'b00, 4'hF, 0, 1'b1, 1));

    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst out_valid",   32'(out_valid),   0);
    chk("rst alu_control", 32'(alu_control), 0);
    chk("rst out_illegal", 32'(out_illegal), 0);
    chk("rst md_start",    32'(md_start),    0);
    chk("rst busy",        32'(busy),        0);
    chk("rst in_ready",    32'(in_ready),    1);

    // Single-cycle op, latency 1, then back to idle.
    step();
    alu_op = 2'b00; funct = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("and out_valid",   32'(out_valid),   1);
    chk("and alu_control", 32'(alu_control), 2);
    step();
    @(negedge clk);
    chk("and idle out_valid", 32'(out_valid), 0);
    chk("and idle in_ready",  32'(in_ready),  1);

    // MUL: start pulse on first busy cycle only, result after the busy window.
    alu_op = 2'b00; funct = 4'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= int'(MDL); i++) begin
      @(negedge clk);
      chk("mul busy",      32'(busy),      1);
      chk("mul md_start",  32'(md_start),  32'(i == 1));
      chk("mul out_valid", 32'(out_valid), 0);
      chk("mul in_ready",  32'(in_ready),  0);
      step();
    end
    @(negedge clk);
    chk("mul out_valid end", 32'(out_valid),   1);
    chk("mul code",          32'(alu_control), 5);
    chk("mul busy end",      32'(busy),        0);
    step();

    // Back-to-back single-cycle ops with funct ignored.
    alu_op = 2'b11; funct = 4'hF; in_valid = 1'b1;
    step();
    alu_op = 2'b01; funct = 4'h9;
    @(negedge clk);
    chk("b2b code0", 32'(alu_control), 0);
    chk("b2b rdy0",  32'(in_ready),    1);
    step();
    alu_op = 2'b10; funct = 4'h7;
    @(negedge clk);
    chk("b2b code1", 32'(alu_control), 1);
    chk("b2b rdy1",  32'(in_ready),    1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b code2",  32'(alu_control), 4);
    chk("b2b valid2", 32'(out_valid),   1);
    chk("b2b ill2",   32'(out_illegal), 0);
    step();

    // Illegal funct held under back-pressure; a competing op must not be taken.
    alu_op = 2'b00; funct = 4'd9; in_valid = 1'b1; out_ready = 1'b0;
    step();
    alu_op = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold out_valid", 32'(out_valid),   1);
      chk("hold code",      32'(alu_control), 0);
      chk("hold illegal",   32'(out_illegal), 1);
      chk("hold in_ready",  32'(in_ready),    0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("hold release code", 32'(alu_control), 0);
    step();
    @(negedge clk);
    chk("hold drained", 32'(out_valid), 0);

    foreach (vt[i]) begin
      alu_op = vt[i].op; funct = vt[i].fn; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("vec in_ready", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        step();
        @(negedge clk);
        n++;
      end
      chk("vec latency", 32'(n),           32'(vt[i].lat));
      chk("vec code",    32'(alu_control), 32'(vt[i].code));
      chk("vec illegal", 32'(out_illegal), 32'(vt[i].ill));
      step();
    end

    // DIV aborted by reset on its second busy cycle.
    alu_op = 2'b00; funct = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("div md_start", 32'(md_start), 1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("div busy before rst", 32'(busy), 1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort out_valid",   32'(out_valid),   0);
    chk("abort alu_control", 32'(alu_control), 0);
    chk("abort out_illegal", 32'(out_illegal), 0);
    chk("abort md_start",    32'(md_start),    0);
    chk("abort busy",        32'(busy),        0);
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      chk("abort no out_valid", 32'(out_valid), 0);
      chk("abort no md_start",  32'(md_start),  0);
    end

    step();
    q.delete();
    rnd_on = 1'b1;
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      alu_op    = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(0, 3));
      funct     = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < int'(MDL) + 3; i++) step();
    rnd_on = 1'b0;
    chk("rnd drained", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
